// File: rtl/crane_mem_pkg.sv
// crane_mem_pkg: shared memory-port widths, channel limit and request record for the arbiter and its peers.
package crane_mem_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MAX_CH = 8;
    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_W-1:0]     addr;
        logic [MEM_DATA_W-1:0]     wdata;
        logic [MEM_DATA_W/8-1:0]   be;
    } mem_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin search from an owned pointer; the pointer moves past the index that actually transferred.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic [IDX_W-1:0]  last,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] c;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = IDX_W'((int'(ptr) + i) % NUM_CH);
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (last == IDX_W'(NUM_CH - 1)) ? '0 : last + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel round-robin arbiter onto one SRAM port, routing read data back via a RD_LAT-deep tag pipe.
// Define MEM_ARB_LOCK_EN to let a channel keep the port across beats with req_lock.
module mem_arbiter
    import crane_mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    input  logic [NUM_CH-1:0]        req_lock,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [DATA_W/8-1:0]      mem_be,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] rr_grant, grant;
    logic [IDX_W-1:0]  rr_idx, gidx;
    logic              xfer;
    logic              tag_v  [RD_LAT];
    logic [IDX_W-1:0]  tag_id [RD_LAT];

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (xfer),
        .last    (gidx),
        .grant   (rr_grant),
        .idx     (rr_idx)
    );

`ifdef MEM_ARB_LOCK_EN
    // Lock is captured with each transfer and only honoured while its owner keeps requesting.
    logic             lock_act;
    logic [IDX_W-1:0] lock_ch;
    logic             hold;
    assign hold  = lock_act && req_valid[lock_ch];
    assign grant = !mem_ready ? '0 : hold ? NUM_CH'(1) << lock_ch : rr_grant;
    assign gidx  = hold ? lock_ch : rr_idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lock_act <= 1'b0;
            lock_ch  <= '0;
        end else if (xfer) begin
            lock_act <= req_lock[gidx];
            lock_ch  <= gidx;
        end else if (!req_valid[lock_ch]) begin
            lock_act <= 1'b0;
        end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign grant = mem_ready ? rr_grant : '0;
    assign gidx  = rr_idx;
`endif

    assign xfer      = |grant;
    assign req_ready = grant;
    assign mem_en    = xfer;
    assign mem_we    = xfer & req_we[gidx];
    assign mem_be    = req_we[gidx] ? req_be[gidx*BE_W +: BE_W] : '1;
    assign mem_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
    assign mem_wdata = req_wdata[gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            tag_v[0]  <= xfer & ~req_we[gidx];
            tag_id[0] <= gidx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            rsp_valid <= tag_v[RD_LAT-1] ? NUM_CH'(1) << tag_id[RD_LAT-1] : '0;
            if (tag_v[RD_LAT-1])
                rsp_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a 2-channel arbiter at RD_LAT=1 and RD_LAT=3.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  v0 = '0, we0 = '0, lock0 = '0, rdy0, rspv0;
    logic [63:0] addr0 = '0, wdata0 = '0;
    logic [7:0]  be0 = '0;
    logic        mready0 = 1'b0, men0, mwe0;
    logic [31:0] mrdata0 = '0, rdata0, maddr0, mwdata0;
    logic [3:0]  mbe0;

    logic [1:0]  v3 = '0, we3 = '0, lock3 = '0, rdy3, rspv3;
    logic [63:0] addr3 = '0, wdata3 = '0;
    logic [7:0]  be3 = '0;
    logic        mready3 = 1'b1, men3, mwe3;
    logic [31:0] mrdata3 = '0, rdata3, maddr3, mwdata3;
    logic [3:0]  mbe3;

    int tests = 0;
    int fails = 0;
    int n0 = 0;
    logic [1:0]  alt_exp [4];
    logic [31:0] alt_addr [4];
    logic [1:0]  lk_exp [4];

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0), .req_be(be0), .req_lock(lock0),
        .rsp_valid(rspv0), .rsp_rdata(rdata0), .mem_en(men0), .mem_we(mwe0),
        .mem_be(mbe0), .mem_addr(maddr0), .mem_wdata(mwdata0),
        .mem_ready(mready0), .mem_rdata(mrdata0)
    );

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_addr(addr3), .req_wdata(wdata3), .req_be(be3), .req_lock(lock3),
        .rsp_valid(rspv3), .rsp_rdata(rdata3), .mem_en(men3), .mem_we(mwe3),
        .mem_be(mbe3), .mem_addr(maddr3), .mem_wdata(mwdata3),
        .mem_ready(mready3), .mem_rdata(mrdata3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        alt_exp  = '{2'b10, 2'b01, 2'b10, 2'b01};
        alt_addr = '{32'h200, 32'h100, 32'h200, 32'h100};
`ifdef MEM_ARB_LOCK_EN
        lk_exp = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
        lk_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        #12;
        chk("rst_ready", rdy0, 0);
        chk("rst_rspv", rspv0, 0);
        chk("rst_rdata", rdata0, 0);
        chk("rst_men", men0, 0);
        chk("rst_mwe", mwe0, 0);
        chk("rst_rspv3", rspv3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // RD_LAT=3: ch0, ch1, ch0 back to back
        v3 = 2'b01; addr3 = {32'h80, 32'h40};
        #1 chk("l3_g0", rdy3, 2'b01);
        tick;
        v3 = 2'b10;
        #1 chk("l3_g1", rdy3, 2'b10);
        chk("l3_addr1", maddr3, 32'h80);
        tick;
        v3 = 2'b01; addr3 = {32'h80, 32'h44};
        #1 chk("l3_g2", rdy3, 2'b01);
        tick;
        v3 = 2'b00; mrdata3 = 32'h1111_0001;
        #1 chk("l3_none", rspv3, 0);
        tick;
        chk("l3_rsp0", rspv3, 2'b01);
        chk("l3_dat0", rdata3, 32'h1111_0001);
        mrdata3 = 32'h2222_0002;
        tick;
        chk("l3_rsp1", rspv3, 2'b10);
        chk("l3_dat1", rdata3, 32'h2222_0002);
        mrdata3 = 32'h3333_0003;
        tick;
        chk("l3_rsp2", rspv3, 2'b01);
        chk("l3_dat2", rdata3, 32'h3333_0003);
        mrdata3 = 32'h0;
        tick;
        chk("l3_idle", rspv3, 0);
        chk("l3_hold", rdata3, 32'h3333_0003);

        // RD_LAT=1 single read from ch0
        v0 = 2'b01; addr0 = {32'h0, 32'h10}; mready0 = 1'b1;
        #1 chk("rd_ready", rdy0, 2'b01);
        chk("rd_men", men0, 1);
        chk("rd_mwe", mwe0, 0);
        chk("rd_addr", maddr0, 32'h10);
        chk("rd_be", mbe0, 4'hf);
        tick;
        v0 = 2'b00; mrdata0 = 32'hDEAD_BEEF;
        #1 chk("rd_early", rspv0, 0);
        chk("rd_idle_men", men0, 0);
        tick;
        chk("rd_rspv", rspv0, 2'b01);
        chk("rd_rdata", rdata0, 32'hDEAD_BEEF);
        mrdata0 = 32'h1234_5678;
        tick;
        chk("rd_drop", rspv0, 0);
        chk("rd_hold", rdata0, 32'hDEAD_BEEF);

        // both channels: pointer sits at 1 after the ch0 read
        addr0 = {32'h200, 32'h100}; v0 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("alt_grant", rdy0, alt_exp[k]);
            chk("alt_addr", maddr0, alt_addr[k]);
            tick;
        end
        v0 = 2'b00;
        tick;
        tick;

        // stall with ch1 pending a write
        mready0 = 1'b0; v0 = 2'b10; we0 = 2'b10;
        be0 = {4'b0011, 4'h0}; wdata0 = {32'hAABB_CCDD, 32'h0};
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_ready", rdy0, 0);
            chk("stall_men", men0, 0);
            tick;
        end
        mready0 = 1'b1;
        #1 chk("wr_ready", rdy0, 2'b10);
        chk("wr_mwe", mwe0, 1);
        chk("wr_be", mbe0, 4'b0011);
        chk("wr_data", mwdata0, 32'hAABB_CCDD);
        tick;
        v0 = 2'b00; we0 = 2'b00;
        for (int k = 0; k < 2; k++) begin
            chk("wr_norsp", rspv0, 0);
            tick;
        end

        // reset one cycle after a read issues
        v0 = 2'b01; addr0 = {32'h0, 32'h10};
        #1 chk("rr_ready", rdy0, 2'b01);
        tick;
        v0 = 2'b00; mrdata0 = 32'hCAFE_F00D; rst_n = 1'b0;
        #1 chk("rr_rspv", rspv0, 0);
        chk("rr_rdata", rdata0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("rr_after1", rspv0, 0);
        tick;
        chk("rr_after2", rspv0, 0);
        chk("rr_rdata2", rdata0, 0);

        // ch0 wants three locked beats, ch1 always pending
        lock0 = 2'b01; we0 = 2'b11; n0 = 0;
        for (int k = 0; k < 4; k++) begin
            v0 = {1'b1, n0 < 3};
            #1 chk("lock_grant", rdy0, lk_exp[k]);
            if (rdy0[0]) n0++;
            tick;
        end
        v0 = 2'b00; lock0 = 2'b00; we0 = 2'b00;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
